tsu_q_arb: RTL and testbench

Arbitrating drain controller for the two timestamp-unit queues (receive and transmit). It sits between the rx/tx timestamp queues and the host-side register file. It pops entries from whichever queue is non-empty, under round-robin or fixed priority, and presents them one at a time on a single valid/ready stream tagged with their source. It replaces per-queue software polling with one ordered record stream.

---
 rtl/tsu_q_arb_pkg.sv | 23 ++
 rtl/tsu_q_arb_rr.sv | 32 +++
 rtl/tsu_q_arb.sv | 121 ++++++++++++
 tb/tb_tsu_q_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tsu_q_arb_pkg.sv
// ============================================================================
// tsu_q_arb_pkg : shared types and constants for the timestamp queue drain
// Revision 1.0
// ============================================================================
`default_nettype none

package tsu_q_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic SRC_RX = 1'b0;
    localparam logic SRC_TX = 1'b1;

    localparam int REC_W = 64;

endpackage

`default_nettype wire

// File: rtl/tsu_q_arb_rr.sv
// ============================================================================
// tsu_q_arb_rr : two-requester round-robin / rx-priority picker
// Revision 1.0
// ============================================================================
`default_nettype none

module tsu_q_arb_rr
    import tsu_q_arb_pkg::*;
#(
    parameter int PRIO = 0
) (
    input  logic req_rx,
    input  logic req_tx,
    input  logic last_src,
    output logic grant_valid,
    output logic grant_src
);

    always_comb begin
        grant_valid = req_rx | req_tx;
        grant_src   = SRC_RX;
        if (req_rx && req_tx) begin
            // On a tie, round-robin hands the grant to whoever was not served last.
            grant_src = (PRIO != 0) ? SRC_RX : ~last_src;
        end else if (req_tx) begin
            grant_src = SRC_TX;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tsu_q_arb.sv
// ============================================================================
// tsu_q_arb : drains the rx/tx timestamp queues into one tagged record stream
// Revision 1.0
// ============================================================================
`default_nettype none

module tsu_q_arb
    import tsu_q_arb_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int PRIO   = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       rx_q_stat,
    input  logic [REC_W-1:0] rx_q_data,
    output logic             rx_q_rd_en,
    input  logic [7:0]       tx_q_stat,
    input  logic [REC_W-1:0] tx_q_data,
    output logic             tx_q_rd_en,
    output logic             ts_valid,
    input  logic             ts_ready,
    output logic [REC_W-1:0] ts_data,
    output logic             ts_src,
    output logic [CNT_W-1:0] rx_pop_cnt,
    output logic [CNT_W-1:0] tx_pop_cnt,
    output logic             busy
);

    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    state_t     state;
    logic       sel_src;
    logic       last_src;
    logic [1:0] wait_cnt;

    logic       req_rx;
    logic       req_tx;
    logic       grant_valid;
    logic       grant_src;

    assign req_rx = (rx_q_stat != 8'd0);
    assign req_tx = (tx_q_stat != 8'd0);

    tsu_q_arb_rr #(
        .PRIO (PRIO)
    ) u_rr (
        .req_rx      (req_rx),
        .req_tx      (req_tx),
        .last_src    (last_src),
        .grant_valid (grant_valid),
        .grant_src   (grant_src)
    );

    // Stat is only looked at in IDLE, by which time any pop has settled in the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sel_src    <= SRC_RX;
            last_src   <= SRC_TX;
            wait_cnt   <= 2'd0;
            rx_q_rd_en <= 1'b0;
            tx_q_rd_en <= 1'b0;
            ts_valid   <= 1'b0;
            ts_data    <= '0;
            ts_src     <= SRC_RX;
            rx_pop_cnt <= '0;
            tx_pop_cnt <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && grant_valid) begin
                        sel_src    <= grant_src;
                        rx_q_rd_en <= (grant_src == SRC_RX);
                        tx_q_rd_en <= (grant_src == SRC_TX);
                        busy       <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    rx_q_rd_en <= 1'b0;
                    tx_q_rd_en <= 1'b0;
                    if (sel_src == SRC_TX) begin
                        tx_pop_cnt <= tx_pop_cnt + CNT_W'(1);
                    end else begin
                        rx_pop_cnt <= rx_pop_cnt + CNT_W'(1);
                    end
                    last_src <= sel_src;
                    wait_cnt <= WAIT_INIT;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        ts_data  <= (sel_src == SRC_TX) ? tx_q_data : rx_q_data;
                        ts_src   <= sel_src;
                        ts_valid <= 1'b1;
                        state    <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                HOLD: begin
                    if (ts_ready) begin
                        ts_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tsu_q_arb.sv
// ============================================================================
// tb_tsu_q_arb : directed bench over three configurations of tsu_q_arb
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_tsu_q_arb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]       en;
    logic [2:0]       rdy;
    logic [2:0][7:0]  rx_load;
    logic [2:0][7:0]  tx_load;
    logic [2:0][7:0]  rx_pops = '0;
    logic [2:0][7:0]  tx_pops = '0;
    logic [2:0][7:0]  rx_stat;
    logic [2:0][7:0]  tx_stat;
    logic [2:0][63:0] rx_data;
    logic [2:0][63:0] tx_data;

    logic        rx_rd0, tx_rd0, v0, src0, busy0;
    logic [63:0] d0;
    logic [15:0] rc0, tc0;
    logic        rx_rd1, tx_rd1, v1, src1, busy1;
    logic [63:0] d1;
    logic [1:0]  rc1, tc1;
    logic        rx_rd2, tx_rd2, v2, src2, busy2;
    logic [63:0] d2;
    logic [15:0] rc2, tc2;

    logic [2:0] rx_rd;
    logic [2:0] tx_rd;
    assign rx_rd = {rx_rd2, rx_rd1, rx_rd0};
    assign tx_rd = {tx_rd2, tx_rd1, tx_rd0};

    // Queue model: fill = loaded - popped; data tracks pops so each entry is unique.
    always_comb begin
        rx_stat = '0;
        tx_stat = '0;
        rx_data = '0;
        tx_data = '0;
        for (int i = 0; i < 3; i++) begin
            rx_stat[i] = rx_load[i] - rx_pops[i];
            tx_stat[i] = tx_load[i] - tx_pops[i];
            rx_data[i] = 64'hA4 + 64'(rx_pops[i]);
            tx_data[i] = 64'h7000 + 64'(tx_pops[i]);
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rx_rd[i]) rx_pops[i] <= rx_pops[i] + 8'd1;
            if (tx_rd[i]) tx_pops[i] <= tx_pops[i] + 8'd1;
        end
    end

    tsu_q_arb #(.RD_LAT(1), .PRIO(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst_n), .en(en[0]),
        .rx_q_stat(rx_stat[0]), .rx_q_data(rx_data[0]), .rx_q_rd_en(rx_rd0),
        .tx_q_stat(tx_stat[0]), .tx_q_data(tx_data[0]), .tx_q_rd_en(tx_rd0),
        .ts_valid(v0), .ts_ready(rdy[0]), .ts_data(d0), .ts_src(src0),
        .rx_pop_cnt(rc0), .tx_pop_cnt(tc0), .busy(busy0)
    );

    tsu_q_arb #(.RD_LAT(1), .PRIO(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst_n), .en(en[1]),
        .rx_q_stat(rx_stat[1]), .rx_q_data(rx_data[1]), .rx_q_rd_en(rx_rd1),
        .tx_q_stat(tx_stat[1]), .tx_q_data(tx_data[1]), .tx_q_rd_en(tx_rd1),
        .ts_valid(v1), .ts_ready(rdy[1]), .ts_data(d1), .ts_src(src1),
        .rx_pop_cnt(rc1), .tx_pop_cnt(tc1), .busy(busy1)
    );

    tsu_q_arb #(.RD_LAT(3), .PRIO(0), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst(rst_n), .en(en[2]),
        .rx_q_stat(rx_stat[2]), .rx_q_data(rx_data[2]), .rx_q_rd_en(rx_rd2),
        .tx_q_stat(tx_stat[2]), .tx_q_data(tx_data[2]), .tx_q_rd_en(tx_rd2),
        .ts_valid(v2), .ts_ready(rdy[2]), .ts_data(d2), .ts_src(src2),
        .rx_pop_cnt(rc2), .tx_pop_cnt(tc2), .busy(busy2)
    );

    // Delivered records ({src, data}) and the cycle numbers of handshakes and pops.
    int          cyc = 0;
    logic [64:0] rec0[$], rec1[$], rec2[$];
    int          rec0_t[$], rec2_t[$], rd0_t[$], rd2_t[$];
    logic [2:0]  prev_rd = '0;
    logic        rd_viol = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (v0 && rdy[0]) begin rec0.push_back({src0, d0}); rec0_t.push_back(cyc); end
        if (v1 && rdy[1]) rec1.push_back({src1, d1});
        if (v2 && rdy[2]) begin rec2.push_back({src2, d2}); rec2_t.push_back(cyc); end
        if (rx_rd0 || tx_rd0) rd0_t.push_back(cyc);
        if (rx_rd2 || tx_rd2) rd2_t.push_back(cyc);
        for (int i = 0; i < 3; i++) begin
            if ((rx_rd[i] && tx_rd[i]) || ((rx_rd[i] || tx_rd[i]) && prev_rd[i])) rd_viol <= 1'b1;
        end
        prev_rd <= rx_rd | tx_rd;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    logic [64:0] rr_exp [6];
    logic [63:0] hold_d;
    logic        stable;
    int          n;

    initial begin
        rr_exp = '{{1'b1, 64'h7001}, {1'b0, 64'hA6}, {1'b1, 64'h7002},
                   {1'b0, 64'hA7},   {1'b1, 64'h7003}, {1'b0, 64'hA8}};
        rst_n   = 1'b0;
        en      = 3'b000;
        rdy     = 3'b111;
        rx_load = '0;
        tx_load = '0;
        repeat (3) @(negedge clk);
        chk("reset_out0", {v0, src0, rx_rd0, tx_rd0, busy0, d0}, '0);
        chk("reset_cnt0", {rc0, tc0}, '0);
        chk("reset_out2", {v2, src2, busy2, rc2, tc2, d2}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single rx entry
        en[0] = 1'b1;
        rx_load[0] = 8'd1;
        for (int k = 0; k < 20 && rec0.size() < 1; k++) @(negedge clk);
        chk("single_rec", rec0[0], {1'b0, 64'hA5});
        chk("single_lat", rec0_t[0] - rd0_t[0], 2);
        chk("single_vfall", v0, 1'b0);
        chk("single_cnt", {rc0, tc0}, {16'd1, 16'd0});

        // Round-robin: rx was served last, so tx wins the first tie
        rx_load[0] = rx_load[0] + 8'd3;
        tx_load[0] = 8'd3;
        for (int k = 0; k < 60 && rec0.size() < 7; k++) @(negedge clk);
        for (int i = 0; i < 6; i++) chk($sformatf("rr_rec%0d", i), rec0[1 + i], rr_exp[i]);
        for (int i = 1; i < 6; i++) chk($sformatf("rr_gap%0d", i), rec0_t[1 + i] - rec0_t[i], 4);
        chk("rr_cnt", {rc0, tc0}, {16'd4, 16'd3});

        // Backpressure
        rdy[0] = 1'b0;
        tx_load[0] = tx_load[0] + 8'd1;
        for (int k = 0; k < 20 && !v0; k++) @(negedge clk);
        hold_d = d0;
        n = rd0_t.size();
        rx_load[0] = rx_load[0] + 8'd1;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!(v0 === 1'b1 && d0 === hold_d && src0 === 1'b1)) stable = 1'b0;
        end
        chk("bp_stable", stable, 1'b1);
        chk("bp_no_rd", rd0_t.size(), n);
        chk("bp_hold", {src0, d0}, {1'b1, 64'h7004});
        n = rec0.size();
        rdy[0] = 1'b1;
        @(negedge clk);
        chk("bp_one", rec0.size(), n + 1);
        chk("bp_rec", rec0[n], {1'b1, 64'h7004});
        chk("bp_vfall", v0, 1'b0);
        for (int k = 0; k < 20 && rec0.size() < n + 2; k++) @(negedge clk);
        chk("bp_next", rec0[n + 1], {1'b0, 64'hA9});

        // en dropped during WAIT
        rx_load[0] = rx_load[0] + 8'd1;
        for (int k = 0; k < 20 && !rx_rd0; k++) @(negedge clk);
        @(negedge clk);
        en[0] = 1'b0;
        tx_load[0] = tx_load[0] + 8'd1;
        n = rec0.size();
        repeat (20) @(negedge clk);
        chk("en_deliver", rec0.size(), n + 1);
        chk("en_rec", rec0[n], {1'b0, 64'hAA});
        chk("en_nopop", {busy0, rc0, tc0}, {1'b0, 16'd6, 16'd4});
        en[0] = 1'b1;
        for (int k = 0; k < 20 && rec0.size() < n + 2; k++) @(negedge clk);
        chk("en_resume", rec0[n + 1], {1'b1, 64'h7005});
        chk("en_cnt", tc0, 16'd5);

        // Strict priority and counter wrap (CNT_W = 2)
        rx_load[1] = 8'd2;
        tx_load[1] = 8'd2;
        en[1] = 1'b1;
        for (int k = 0; k < 40 && rec1.size() < 4; k++) @(negedge clk);
        chk("prio_rec0", rec1[0], {1'b0, 64'hA5});
        chk("prio_rec1", rec1[1], {1'b0, 64'hA6});
        chk("prio_rec2", rec1[2], {1'b1, 64'h7001});
        chk("prio_rec3", rec1[3], {1'b1, 64'h7002});
        chk("prio_cnt", {rc1, tc1}, {2'd2, 2'd2});
        rx_load[1] = rx_load[1] + 8'd2;
        for (int k = 0; k < 20 && rec1.size() < 5; k++) @(negedge clk);
        chk("wrap_max", rc1, 2'd3);
        for (int k = 0; k < 20 && rec1.size() < 6; k++) @(negedge clk);
        chk("wrap_zero", rc1, 2'd0);
        chk("wrap_busy", busy1, 1'b0);

        // Async reset during WAIT with RD_LAT = 3
        rx_load[2] = 8'd1;
        tx_load[2] = 8'd1;
        en[2] = 1'b1;
        for (int k = 0; k < 20 && !(rx_rd2 || tx_rd2); k++) @(negedge clk);
        chk("pre_rst_src", {rx_rd2, tx_rd2}, 2'b10);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_state", {busy2, rc2}, {1'b1, 16'd1});
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out", {v2, src2, rx_rd2, tx_rd2, busy2, d2}, '0);
        chk("rst_cnt", {rc2, tc2}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        rx_load[2] = rx_load[2] + 8'd1;
        for (int k = 0; k < 30 && rec2.size() < 1; k++) @(negedge clk);
        chk("post_rst_rec", rec2[0], {1'b0, 64'hA6});
        chk("post_rst_lat", rec2_t[0] - rd2_t[rd2_t.size() - 1], 4);
        for (int k = 0; k < 30 && rec2.size() < 2; k++) @(negedge clk);
        chk("post_rst_rec2", rec2[1], {1'b1, 64'h7001});
        chk("post_rst_cnt", {rc2, tc2}, {16'd1, 16'd1});

        chk("rd_en_rules", rd_viol, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
